// File: rtl/rob_completion_arbiter_pkg.sv
// Shared out-of-order core types and defaults for ROB completion traffic.
// Used by the completion arbiter and the reorder buffer.
package rob_completion_arbiter_pkg;

    localparam int unsigned DEF_NUM_REQ     = 4;
    localparam int unsigned DEF_ROB_ENTRIES = 64;
    localparam int unsigned DEF_ROB_PTR_W   = $clog2(DEF_ROB_ENTRIES);
    localparam int unsigned DEF_REQ_IDX_W   = $clog2(DEF_NUM_REQ);

    typedef struct packed {
        logic [DEF_ROB_PTR_W-1:0] rob_idx;
        logic                     exc;
        logic [DEF_REQ_IDX_W-1:0] src;
    } rob_completion_t;

    // Modulo increment that stays correct for non-power-of-two n.
    function automatic int unsigned rr_wrap_inc(
        input int unsigned i,
        input int unsigned n
    );
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rob_completion_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i wins.
// Shared with the issue-select logic.
module rr_arbiter
    import rob_completion_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    logic [NUM_REQ-1:0] rot;
    logic               found;
    int                 off;
    int                 sum;

    always_comb begin
        // Rotate so that bit 0 is the highest-priority requester.
        rot   = NUM_REQ'({req_i, req_i} >> ptr_i);
        found = 1'b0;
        off   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = int'(ptr_i) + off;
        if (sum >= int'(NUM_REQ)) begin
            sum = sum - int'(NUM_REQ);
        end
        vld_o = en_i & found;
        idx_o = vld_o ? IDX_W'(sum) : '0;
        gnt_o = vld_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/rob_completion_arbiter.sv
// Round-robin arbitration of execution-unit completions onto the single
// ROB mark-ready port, through a one-entry registered output stage.
module rob_completion_arbiter
    import rob_completion_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
    parameter int unsigned ROB_ENTRIES   = DEF_ROB_ENTRIES,
    parameter int unsigned ROB_PTR_WIDTH = $clog2(ROB_ENTRIES),
    parameter int unsigned REQ_IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*ROB_PTR_WIDTH-1:0]  req_rob_idx,
    input  logic [NUM_REQ-1:0]                req_exc,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic                              flush,
    output logic                              rob_wb_valid,
    output logic [ROB_PTR_WIDTH-1:0]          rob_wb_idx,
    output logic                              rob_wb_exc,
    output logic [REQ_IDX_WIDTH-1:0]          rob_wb_src,
    input  logic                              rob_wb_ready,
    output logic                              busy
);

    typedef struct packed {
        logic [ROB_PTR_WIDTH-1:0] rob_idx;
        logic                     exc;
        logic [REQ_IDX_WIDTH-1:0] src;
    } stage_t;

    logic                     valid_q, valid_d;
    stage_t                   stage_q, stage_d;
    logic [REQ_IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic                     can_accept;
    logic                     grant_en;
    logic [NUM_REQ-1:0]       gnt;
    logic [REQ_IDX_WIDTH-1:0] gnt_idx;
    logic                     gnt_vld;
    logic [ROB_PTR_WIDTH-1:0] sel_idx;
    logic                     sel_exc;

    assign can_accept = !valid_q || rob_wb_ready;
    assign grant_en   = can_accept && !flush && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_IDX_WIDTH)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (grant_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    assign req_ready = gnt;

    // One-hot AND-OR mux of the winner's payload.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_idx = sel_idx
                    | (req_rob_idx[i*ROB_PTR_WIDTH +: ROB_PTR_WIDTH]
                       & {ROB_PTR_WIDTH{gnt[i]}});
        end
        sel_exc = |(req_exc & gnt);
    end

    always_comb begin
        valid_d  = valid_q;
        stage_d  = stage_q;
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            valid_d         = 1'b1;
            stage_d.rob_idx = sel_idx;
            stage_d.exc     = sel_exc;
            stage_d.src     = gnt_idx;
            rr_ptr_d        = REQ_IDX_WIDTH'(
                rr_wrap_inc(32'(gnt_idx), NUM_REQ));
        end else if (flush || rob_wb_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            stage_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            stage_q  <= stage_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rob_wb_valid = valid_q;
    assign rob_wb_idx   = stage_q.rob_idx;
    assign rob_wb_exc   = stage_q.exc;
    assign rob_wb_src   = stage_q.src;
    assign busy         = valid_q;

endmodule
